parking_ramp_arbiter: RTL and testbench



---
 rtl/parking_pkg.sv | 24 ++
 rtl/parking_ramp_arbiter_gate_timer.sv | 38 +++
 rtl/parking_ramp_arbiter.sv | 164 ++++++++++++++++
 tb/tb_parking_ramp_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// parking_pkg
// Shared types and default constants for the parking ramp arbiter.
//   ramp_state_t : ramp FSM states (IDLE, GRANT_IN, GRANT_OUT, TURN)
//   dir_t        : direction of the most recent grant (IN, OUT)
//   DEFAULT_*    : default parameter values for the arbiter
package parking_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT_IN  = 2'd1,
        GRANT_OUT = 2'd2,
        TURN      = 2'd3
    } ramp_state_t;

    typedef enum logic {
        IN  = 1'b0,
        OUT = 1'b1
    } dir_t;

    localparam int DEFAULT_CAPACITY       = 8;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1000;
    localparam int DEFAULT_TURNAROUND     = 4;

endpackage

// File: rtl/parking_ramp_arbiter_gate_timer.sv
// gate_timer
// Cycle counter used for both the grant timeout and the turnaround hold.
// Counts up from zero while enable is high; expired is high while the
// count sits at LIMIT-1, i.e. during the LIMIT-th enabled cycle.
//   clk     in  : clock, rising edge
//   rst     in  : asynchronous active-high reset
//   clear   in  : synchronous clear to zero (wins over enable)
//   enable  in  : advance the count by one this cycle
//   expired out : count == LIMIT-1 (combinational from the count register)
module gate_timer #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [W-1:0] count;

    // The count saturates at LIMIT-1 so it cannot wrap if the owner
    // lingers in the counting state for an extra cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == W'(LIMIT - 1));

endmodule

// File: rtl/parking_ramp_arbiter.sv
// parking_ramp_arbiter
// Grants a single-lane ramp to the entry or exit lane, opens that lane's
// gate until a passage pulse or timeout, then holds both gates closed for
// a turnaround period. Tracks lot occupancy and blocks entry when full.
//   clk, rst         in  : clock, asynchronous active-high reset
//   entry_req        in  : car waiting at the entry loop (level)
//   exit_req         in  : car waiting at the exit loop (level)
//   car_entered      in  : one-cycle pulse, car passed the entry gate
//   car_exited       in  : one-cycle pulse, car passed the exit gate
//   entry_gate_open  out : entry gate open command
//   exit_gate_open   out : exit gate open command
//   ramp_busy        out : FSM not in IDLE
//   lot_full         out : occupancy == CAPACITY
//   occupancy        out : cars currently in the lot
//   timeout_err      out : one-cycle pulse after a grant expires unused
//   state            out : current FSM state (debug visibility)
// Handshake: requests are levels sampled only in IDLE; passage pulses are
// accepted only in the matching GRANT state and are ignored elsewhere.
module parking_ramp_arbiter
    import parking_pkg::*;
#(
    parameter int CAPACITY       = DEFAULT_CAPACITY,
    parameter int COUNT_W        = $clog2(CAPACITY + 1),
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int TURNAROUND     = DEFAULT_TURNAROUND
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               entry_req,
    input  logic               exit_req,
    input  logic               car_entered,
    input  logic               car_exited,
    output logic               entry_gate_open,
    output logic               exit_gate_open,
    output logic               ramp_busy,
    output logic               lot_full,
    output logic [COUNT_W-1:0] occupancy,
    output logic               timeout_err,
    output logic [1:0]         state
);

    localparam logic [1:0] ST_IDLE      = IDLE;
    localparam logic [1:0] ST_GRANT_IN  = GRANT_IN;
    localparam logic [1:0] ST_GRANT_OUT = GRANT_OUT;
    localparam logic [1:0] ST_TURN      = TURN;

    localparam logic [COUNT_W-1:0] CAP = COUNT_W'(CAPACITY);

    logic [1:0]         state_q;
    logic [1:0]         state_next;
    dir_t               last_dir;
    dir_t               dir_next;
    logic [COUNT_W-1:0] occ_next;
    logic               err_next;
    logic               in_grant;
    logic               in_turn;
    logic               grant_expired;
    logic               turn_expired;
    logic               entry_ok;
    logic               exit_ok;

    assign in_grant = (state_q == ST_GRANT_IN) || (state_q == ST_GRANT_OUT);
    assign in_turn  = (state_q == ST_TURN);

    // Both timers are held at zero outside their state, so the count is
    // already zero on the first cycle of each GRANT or TURN.
    gate_timer #(.LIMIT(TIMEOUT_CYCLES)) u_grant_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!in_grant),
        .enable  (in_grant),
        .expired (grant_expired)
    );

    gate_timer #(.LIMIT(TURNAROUND)) u_turn_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!in_turn),
        .enable  (in_turn),
        .expired (turn_expired)
    );

    assign entry_ok = entry_req && !lot_full;
    assign exit_ok  = exit_req && (occupancy != '0);

    always_comb begin
        state_next = state_q;
        dir_next   = last_dir;
        occ_next   = occupancy;
        err_next   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Round-robin on contention: favour the opposite of the
                // direction served last.
                if (entry_ok && exit_ok) begin
                    state_next = (last_dir == OUT) ? ST_GRANT_IN : ST_GRANT_OUT;
                end else if (entry_ok) begin
                    state_next = ST_GRANT_IN;
                end else if (exit_ok) begin
                    state_next = ST_GRANT_OUT;
                end
            end
            ST_GRANT_IN: begin
                // A passage on the expiry cycle takes priority over the timeout.
                if (car_entered) begin
                    if (occupancy != CAP) begin
                        occ_next = occupancy + 1'b1;
                    end
                    dir_next   = IN;
                    state_next = ST_TURN;
                end else if (grant_expired) begin
                    err_next   = 1'b1;
                    dir_next   = IN;
                    state_next = ST_TURN;
                end
            end
            ST_GRANT_OUT: begin
                if (car_exited) begin
                    if (occupancy != '0) begin
                        occ_next = occupancy - 1'b1;
                    end
                    dir_next   = OUT;
                    state_next = ST_TURN;
                end else if (grant_expired) begin
                    err_next   = 1'b1;
                    dir_next   = OUT;
                    state_next = ST_TURN;
                end
            end
            default: begin
                if (turn_expired) begin
                    state_next = ST_IDLE;
                end
            end
        endcase
    end

    // Outputs are registered from the next-state values so they change on
    // the same edge as the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            last_dir        <= OUT;
            occupancy       <= '0;
            lot_full        <= 1'b0;
            entry_gate_open <= 1'b0;
            exit_gate_open  <= 1'b0;
            ramp_busy       <= 1'b0;
            timeout_err     <= 1'b0;
        end else begin
            state_q         <= state_next;
            last_dir        <= dir_next;
            occupancy       <= occ_next;
            lot_full        <= (occ_next == CAP);
            entry_gate_open <= (state_next == ST_GRANT_IN);
            exit_gate_open  <= (state_next == ST_GRANT_OUT);
            ramp_busy       <= (state_next != ST_IDLE);
            timeout_err     <= err_next;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_parking_ramp_arbiter.sv
// tb_parking_ramp_arbiter
// Directed scenarios for parking_ramp_arbiter with CAPACITY=2,
// TIMEOUT_CYCLES=10, TURNAROUND=4. Inputs change 1 time unit after the
// rising edge; outputs are read at the same point.
module tb_parking_ramp_arbiter;

    localparam int CAPACITY       = 2;
    localparam int COUNT_W        = $clog2(CAPACITY + 1);
    localparam int TIMEOUT_CYCLES = 10;
    localparam int TURNAROUND     = 4;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic               entry_req   = 1'b0;
    logic               exit_req    = 1'b0;
    logic               car_entered = 1'b0;
    logic               car_exited  = 1'b0;
    logic               entry_gate_open;
    logic               exit_gate_open;
    logic               ramp_busy;
    logic               lot_full;
    logic [COUNT_W-1:0] occupancy;
    logic               timeout_err;
    logic [1:0]         state;

    int n_vec = 0;
    int n_err = 0;

    parking_ramp_arbiter #(
        .CAPACITY       (CAPACITY),
        .COUNT_W        (COUNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TURNAROUND     (TURNAROUND)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .entry_req       (entry_req),
        .exit_req        (exit_req),
        .car_entered     (car_entered),
        .car_exited      (car_exited),
        .entry_gate_open (entry_gate_open),
        .exit_gate_open  (exit_gate_open),
        .ramp_busy       (ramp_busy),
        .lot_full        (lot_full),
        .occupancy       (occupancy),
        .timeout_err     (timeout_err),
        .state           (state)
    );

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns 1 for an entry grant, 2 for an exit grant, 0 if none within bound.
    task automatic wait_grant(output int dir);
        dir = 0;
        for (int i = 0; i < 20; i++) begin
            if (entry_gate_open) begin dir = 1; return; end
            if (exit_gate_open)  begin dir = 2; return; end
            tick();
        end
    endtask

    // Called on the first open cycle. Optionally pulses the matching
    // passage line during open cycle pulse_at; counts open cycles and
    // timeout pulses up to one cycle past the close.
    task automatic hold_grant(input bit do_pulse, input int pulse_at,
                              output int open_cycles, output int errs,
                              output bit both);
        bit is_in;
        is_in       = entry_gate_open;
        open_cycles = 0;
        errs        = 0;
        both        = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!(entry_gate_open || exit_gate_open)) break;
            open_cycles++;
            if (entry_gate_open && exit_gate_open) both = 1'b1;
            if (do_pulse && open_cycles == pulse_at) begin
                if (is_in) car_entered = 1'b1;
                else       car_exited  = 1'b1;
            end
            tick();
            car_entered = 1'b0;
            car_exited  = 1'b0;
            if (timeout_err) errs++;
        end
        tick();
        if (timeout_err) errs++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        n_vec++; if ({entry_gate_open, exit_gate_open} !== 2'b00) begin n_err++; $display("FAIL reset_gates: got %b expected 00", {entry_gate_open, exit_gate_open}); end
        n_vec++; if (occupancy !== 0) begin n_err++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
        n_vec++; if ({ramp_busy, lot_full, timeout_err} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b expected 000", {ramp_busy, lot_full, timeout_err}); end
    endtask

    task automatic test_empty_exit();
        int seen;
        seen = 0;
        exit_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (exit_gate_open || ramp_busy) seen++;
        end
        exit_req = 1'b0;
        n_vec++; if (seen !== 0) begin n_err++; $display("FAIL empty_exit: got %0d busy cycles expected 0", seen); end
    endtask

    task automatic test_basic_entry();
        int open_ok;
        open_ok = 0;
        entry_req = 1'b1;
        tick();                                  // grant edge
        if (entry_gate_open) open_ok++;
        car_exited = 1'b1;                       // stray pulse in GRANT_IN
        tick();
        car_exited = 1'b0;
        if (entry_gate_open) open_ok++;
        n_vec++; if (occupancy !== 0) begin n_err++; $display("FAIL stray_exit_occ: got %0d expected 0", occupancy); end
        tick(); if (entry_gate_open) open_ok++;
        tick(); if (entry_gate_open) open_ok++;
        n_vec++; if (open_ok !== 4) begin n_err++; $display("FAIL entry_open_cycles: got %0d expected 4", open_ok); end
        car_entered = 1'b1;
        entry_req   = 1'b0;
        tick();                                  // passage edge M
        car_entered = 1'b0;
        n_vec++; if ({entry_gate_open, ramp_busy} !== 2'b01) begin n_err++; $display("FAIL entry_close: got %b expected 01", {entry_gate_open, ramp_busy}); end
        n_vec++; if (occupancy !== 1) begin n_err++; $display("FAIL entry_occ: got %0d expected 1", occupancy); end
        tick(); tick(); tick();                  // cycle M+4, still TURN
        n_vec++; if (ramp_busy !== 1'b1) begin n_err++; $display("FAIL turn_hold: got %b expected 1", ramp_busy); end
        tick();                                  // cycle M+5, IDLE
        n_vec++; if (ramp_busy !== 1'b0) begin n_err++; $display("FAIL turn_release: got %b expected 0", ramp_busy); end
    endtask

    // occupancy 1, last grant IN: contention should serve OUT, IN, OUT.
    task automatic test_round_robin();
        int dir, oc, errs;
        bit both;
        int exp_dir[3] = '{2, 1, 2};
        entry_req = 1'b1;
        exit_req  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_grant(dir);
            n_vec++; if (dir !== exp_dir[k]) begin n_err++; $display("FAIL rr_dir_%0d: got %0d expected %0d", k, dir, exp_dir[k]); end
            hold_grant(1'b0, 0, oc, errs, both);
            n_vec++; if (oc !== TIMEOUT_CYCLES) begin n_err++; $display("FAIL rr_open_%0d: got %0d expected %0d", k, oc, TIMEOUT_CYCLES); end
            n_vec++; if (errs !== 1) begin n_err++; $display("FAIL rr_err_%0d: got %0d expected 1", k, errs); end
            n_vec++; if (both !== 1'b0) begin n_err++; $display("FAIL rr_both_gates_%0d: got 1 expected 0", k); end
            n_vec++; if (occupancy !== 1) begin n_err++; $display("FAIL rr_occ_%0d: got %0d expected 1", k, occupancy); end
        end
        entry_req = 1'b0;
        exit_req  = 1'b0;
    endtask

    task automatic test_full_lot();
        int dir, oc, errs, seen;
        bit both;
        entry_req = 1'b1;
        wait_grant(dir);
        entry_req = 1'b0;
        n_vec++; if (dir !== 1) begin n_err++; $display("FAIL fill_dir: got %0d expected 1", dir); end
        hold_grant(1'b1, 2, oc, errs, both);
        n_vec++; if ({occupancy, lot_full} !== {COUNT_W'(2), 1'b1}) begin n_err++; $display("FAIL full_flag: got occ %0d full %b expected occ 2 full 1", occupancy, lot_full); end
        entry_req = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (entry_gate_open) seen++;
        end
        n_vec++; if ({seen, ramp_busy} !== {32'd0, 1'b0}) begin n_err++; $display("FAIL full_blocks_entry: got %0d grants busy %b expected 0 grants busy 0", seen, ramp_busy); end
        exit_req = 1'b1;
        wait_grant(dir);
        exit_req = 1'b0;
        n_vec++; if (dir !== 2) begin n_err++; $display("FAIL full_exit_dir: got %0d expected 2", dir); end
        hold_grant(1'b1, 1, oc, errs, both);
        n_vec++; if ({occupancy, lot_full} !== {COUNT_W'(1), 1'b0}) begin n_err++; $display("FAIL unfull: got occ %0d full %b expected occ 1 full 0", occupancy, lot_full); end
        wait_grant(dir);
        entry_req = 1'b0;
        n_vec++; if (dir !== 1) begin n_err++; $display("FAIL reentry_dir: got %0d expected 1", dir); end
        hold_grant(1'b1, 3, oc, errs, both);
        n_vec++; if (occupancy !== 2) begin n_err++; $display("FAIL reentry_occ: got %0d expected 2", occupancy); end
    endtask

    task automatic test_timeout();
        int dir, oc, errs;
        bit both;
        exit_req = 1'b1;
        wait_grant(dir);
        exit_req = 1'b0;
        hold_grant(1'b1, TIMEOUT_CYCLES, oc, errs, both);   // pulse on expiry cycle
        n_vec++; if (oc !== TIMEOUT_CYCLES) begin n_err++; $display("FAIL edge_open: got %0d expected %0d", oc, TIMEOUT_CYCLES); end
        n_vec++; if (errs !== 0) begin n_err++; $display("FAIL edge_err: got %0d expected 0", errs); end
        n_vec++; if (occupancy !== 1) begin n_err++; $display("FAIL edge_occ: got %0d expected 1", occupancy); end
        entry_req = 1'b1;
        wait_grant(dir);
        entry_req = 1'b0;
        n_vec++; if (dir !== 1) begin n_err++; $display("FAIL tmo_dir: got %0d expected 1", dir); end
        hold_grant(1'b0, 0, oc, errs, both);
        n_vec++; if (oc !== TIMEOUT_CYCLES) begin n_err++; $display("FAIL tmo_open: got %0d expected %0d", oc, TIMEOUT_CYCLES); end
        n_vec++; if (errs !== 1) begin n_err++; $display("FAIL tmo_err: got %0d expected 1", errs); end
        n_vec++; if (occupancy !== 1) begin n_err++; $display("FAIL tmo_occ: got %0d expected 1", occupancy); end
    endtask

    task automatic test_async_reset();
        int dir, oc, errs;
        bit both;
        exit_req = 1'b1;
        wait_grant(dir);
        n_vec++; if (dir !== 2) begin n_err++; $display("FAIL ar_grant: got %0d expected 2", dir); end
        tick();
        #2 rst = 1'b1;
        #1;                                      // still before the next edge
        n_vec++; if ({entry_gate_open, exit_gate_open, ramp_busy} !== 3'b000) begin n_err++; $display("FAIL ar_gates: got %b expected 000", {entry_gate_open, exit_gate_open, ramp_busy}); end
        n_vec++; if ({occupancy, lot_full} !== {COUNT_W'(0), 1'b0}) begin n_err++; $display("FAIL ar_occ: got occ %0d full %b expected occ 0 full 0", occupancy, lot_full); end
        exit_req = 1'b0;
        tick();
        #2 rst = 1'b0;
        entry_req = 1'b1;
        exit_req  = 1'b1;
        wait_grant(dir);
        entry_req = 1'b0;
        exit_req  = 1'b0;
        n_vec++; if (dir !== 1) begin n_err++; $display("FAIL ar_first_grant: got %0d expected 1", dir); end
        hold_grant(1'b1, 1, oc, errs, both);
        n_vec++; if (occupancy !== 1) begin n_err++; $display("FAIL ar_post_occ: got %0d expected 1", occupancy); end
    endtask

    initial begin
        test_reset();
        test_empty_exit();
        test_basic_entry();
        test_round_robin();
        test_full_lot();
        test_timeout();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
